// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the Avalon-MM SPI front-end: register map, bit
// positions and sequencer state encoding.
package spi_ctrl_pkg;

    localparam logic [1:0] ADDR_TX     = 2'd0;
    localparam logic [1:0] ADDR_RX     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY = 16;
    localparam int ST_TX_FULL  = 17;
    localparam int ST_RX_EMPTY = 18;
    localparam int ST_RX_FULL  = 19;
    localparam int ST_BUSY     = 20;
    localparam int ST_TX_OVF   = 24;
    localparam int ST_RX_UNF   = 25;

    localparam int CT_EN     = 8;
    localparam int CT_IE_RX  = 9;
    localparam int CT_IE_TXE = 10;

    // Cycles spent in WAITB without Busy before the word is abandoned
    localparam logic [2:0] WAITB_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAITB = 3'd2,
        S_XFER  = 3'd3,
        S_CAPT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/spi_avalon_ctrl_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == DEPTH_C);
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at 2**AW
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_avalon_ctrl.sv
// Avalon-MM slave that queues 32-bit SPI words, sequences the SPI master one
// word at a time and collects received words for the CPU.
module spi_avalon_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter int         AW      = 3,
    parameter logic [7:0] DIV_RST = 8'h04
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        spi_start,
    output logic [31:0] spi_data_in,
    output logic [7:0]  spi_clock_div,
    input  logic        spi_busy,
    input  logic [31:0] spi_data_out
);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    seq_state_t  state_r, state_next_s;
    logic [2:0]  wcnt_r;
    logic [7:0]  div_r;
    logic        en_r, ie_rx_r, ie_txe_r;
    logic        tx_ovf_r, rx_unf_r;

    logic        wr_tx_s, wr_status_s, wr_ctrl_s, rd_rx_s;
    logic        go_load_s, rx_push_s, inflight_s, room_s;
    logic [31:0] tx_rdata_s, rx_rdata_s, status_s, ctrl_s, rd_mux_s;
    logic [AW:0] tx_count_s, rx_count_s;
    logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;

    assign wr_tx_s     = avs_write && (avs_address == ADDR_TX);
    assign wr_status_s = avs_write && (avs_address == ADDR_STATUS);
    assign wr_ctrl_s   = avs_write && (avs_address == ADDR_CTRL);
    assign rd_rx_s     = avs_read  && (avs_address == ADDR_RX);

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(32)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(wr_tx_s), .pop(go_load_s),
        .wdata(avs_writedata), .rdata(tx_rdata_s), .count(tx_count_s),
        .empty(tx_empty_s), .full(tx_full_s)
    );

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(32)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push_s), .pop(rd_rx_s),
        .wdata(spi_data_out), .rdata(rx_rdata_s), .count(rx_count_s),
        .empty(rx_empty_s), .full(rx_full_s)
    );

    // A word is only launched when its RX slot is already guaranteed
    assign inflight_s = (state_r != S_IDLE);
    assign room_s = (({1'b0, rx_count_s} + {{(AW+1){1'b0}}, inflight_s}) < DEPTH_W);

    // Sequencer next-state and per-state strobes
    always_comb begin
        state_next_s = state_r;
        go_load_s    = 1'b0;
        rx_push_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (en_r && !tx_empty_s && room_s) begin
                    state_next_s = S_LOAD;
                    go_load_s    = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD: state_next_s = S_WAITB;
            S_WAITB: begin
                if (spi_busy) begin
                    state_next_s = S_XFER;
                end else if (wcnt_r == (WAITB_TIMEOUT - 3'd1)) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAITB;
                end
            end
            S_XFER: begin
                if (!spi_busy) begin
                    state_next_s = S_CAPT;
                end else begin
                    state_next_s = S_XFER;
                end
            end
            S_CAPT: begin
                rx_push_s    = 1'b1;
                state_next_s = S_IDLE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sequencer state, WAITB timer and SPI master drive
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= S_IDLE;
            wcnt_r        <= 3'd0;
            spi_start     <= 1'b0;
            spi_data_in   <= 32'd0;
            spi_clock_div <= DIV_RST;
        end else begin
            state_r   <= state_next_s;
            wcnt_r    <= (state_r == S_WAITB) ? (wcnt_r + 3'd1) : 3'd0;
            // Start is registered so it coincides with the LOAD cycle
            spi_start <= go_load_s;
            if (go_load_s) begin
                spi_data_in   <= tx_rdata_s;
                spi_clock_div <= div_r;
            end
        end
    end

    // Control register and sticky error flags (a new error wins over W1C)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_r    <= DIV_RST;
            en_r     <= 1'b0;
            ie_rx_r  <= 1'b0;
            ie_txe_r <= 1'b0;
            tx_ovf_r <= 1'b0;
            rx_unf_r <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                div_r    <= avs_writedata[7:0];
                en_r     <= avs_writedata[CT_EN];
                ie_rx_r  <= avs_writedata[CT_IE_RX];
                ie_txe_r <= avs_writedata[CT_IE_TXE];
            end
            if (wr_tx_s && tx_full_s) begin
                tx_ovf_r <= 1'b1;
            end else if (wr_status_s && avs_writedata[ST_TX_OVF]) begin
                tx_ovf_r <= 1'b0;
            end
            if (rd_rx_s && rx_empty_s) begin
                rx_unf_r <= 1'b1;
            end else if (wr_status_s && avs_writedata[ST_RX_UNF]) begin
                rx_unf_r <= 1'b0;
            end
        end
    end

    // Readback words assembled from current (pre-write) register values
    always_comb begin
        status_s = 32'd0;
        status_s[7:0]       = 8'(tx_count_s);
        status_s[15:8]      = 8'(rx_count_s);
        status_s[ST_TX_EMPTY] = tx_empty_s;
        status_s[ST_TX_FULL]  = tx_full_s;
        status_s[ST_RX_EMPTY] = rx_empty_s;
        status_s[ST_RX_FULL]  = rx_full_s;
        status_s[ST_BUSY]     = inflight_s;
        status_s[ST_TX_OVF]   = tx_ovf_r;
        status_s[ST_RX_UNF]   = rx_unf_r;
        ctrl_s = 32'd0;
        ctrl_s[7:0]        = div_r;
        ctrl_s[CT_EN]      = en_r;
        ctrl_s[CT_IE_RX]   = ie_rx_r;
        ctrl_s[CT_IE_TXE]  = ie_txe_r;
        case (avs_address)
            ADDR_RX:     rd_mux_s = rx_empty_s ? 32'd0 : rx_rdata_s;
            ADDR_STATUS: rd_mux_s = status_s;
            ADDR_CTRL:   rd_mux_s = ctrl_s;
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data and level interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            avs_readdata <= 32'd0;
            irq          <= 1'b0;
        end else begin
            if (avs_read) avs_readdata <= rd_mux_s;
            irq <= (ie_rx_r & ~rx_empty_s) | (ie_txe_r & tx_empty_s & ~inflight_s);
        end
    end

endmodule

// File: tb/tb_spi_avalon_ctrl.sv
// Randomized self-checking bench: queue-level reference model of the register
// map plus a loopback SPI master model that checks every launched word.
module tb_spi_avalon_ctrl;
    localparam int DEPTH = 8;
    localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_ST = 2'd2, A_CT = 2'd3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0, avs_read = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq, spi_start;
    logic [31:0] spi_data_in;
    logic [7:0]  spi_clock_div;
    logic        spi_busy = 1'b0;
    logic [31:0] spi_data_out = 32'd0;

    spi_avalon_ctrl #(.DEPTH(DEPTH), .AW(3), .DIV_RST(8'h04)) dut (
        .clk(clk), .rstn(rstn), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .irq(irq), .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_clock_div(spi_clock_div), .spi_busy(spi_busy), .spi_data_out(spi_data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    // Reference model state
    logic [31:0] tx_q[$], rx_q[$];
    logic [7:0]  m_div = 8'h04;
    logic        m_en = 1'b0, m_ierx = 1'b0, m_ietxe = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    // SPI master model state
    int          m_phase = 0, m_cnt = 0, m_quiet = 0, starts = 0;
    logic [31:0] m_cap;
    logic [7:0]  m_lat_div;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[7:0]  = 8'(tx_q.size());
        s[15:8] = 8'(rx_q.size());
        s[16] = (tx_q.size() == 0);
        s[17] = (tx_q.size() == DEPTH);
        s[18] = (rx_q.size() == 0);
        s[19] = (rx_q.size() == DEPTH);
        s[24] = m_ovf;
        s[25] = m_unf;
        return s;
    endfunction

    function automatic logic [31:0] exp_ctrl();
        return {21'd0, m_ietxe, m_ierx, m_en, m_div};
    endfunction

    function automatic logic launch_ok();
        return m_en && (tx_q.size() > 0) && (rx_q.size() < DEPTH);
    endfunction

    function automatic void model_reset();
        tx_q.delete(); rx_q.delete();
        m_div = 8'h04; m_en = 1'b0; m_ierx = 1'b0; m_ietxe = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
    endfunction

    // Loopback SPI master: Busy one cycle after Start, length scales with div
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            m_phase = 0; spi_busy = 1'b0; m_quiet = 0;
        end else begin
            case (m_phase)
                0: if (spi_start) begin
                    chk("start_allowed", {31'd0, launch_ok()}, 32'd1);
                    if (tx_q.size() > 0) chk("spi_data_in", spi_data_in, tx_q.pop_front());
                    chk("spi_clock_div", {24'd0, spi_clock_div}, {24'd0, m_div});
                    m_cap = spi_data_in; m_lat_div = spi_clock_div;
                    starts++; m_phase = 1;
                end
                1: begin
                    chk("start_width", {31'd0, spi_start}, 32'd0);
                    spi_busy = 1'b1; spi_data_out = m_cap;
                    m_cnt = 2 * int'(m_lat_div) + 3; m_phase = 2;
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        chk("div_hold", {24'd0, spi_clock_div}, {24'd0, m_lat_div});
                        spi_busy = 1'b0; rx_q.push_back(m_cap); m_phase = 0;
                    end
                end
            endcase
            m_quiet = (m_phase == 0 && !spi_start) ? m_quiet + 1 : 0;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        case (a)
            A_TX: if (tx_q.size() < DEPTH) tx_q.push_back(d); else m_ovf = 1'b1;
            A_ST: begin
                if (d[24]) m_ovf = 1'b0;
                if (d[25]) m_unf = 1'b0;
            end
            A_CT: begin
                m_div = d[7:0]; m_en = d[8]; m_ierx = d[9]; m_ietxe = d[10];
            end
            default: ;
        endcase
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic settle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (!(m_quiet >= 6 && !launch_ok()) && n < 3000) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) chk("settle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d, e;
        e = exp_status();
        bus_read(A_ST, d);
        chk(tag, d, e);
    endtask

    task automatic check_ctrl(input string tag);
        logic [31:0] d, e;
        e = exp_ctrl();
        bus_read(A_CT, d);
        chk(tag, d, e);
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] d, e;
        if (rx_q.size() == 0) begin e = 32'd0; m_unf = 1'b1; end
        else e = rx_q.pop_front();
        bus_read(A_RX, d);
        chk(tag, d, e);
    endtask

    task automatic check_irq(input string tag);
        chk(tag, {31'd0, irq}, {31'd0, (m_ierx && rx_q.size() > 0) || (m_ietxe && tx_q.size() == 0)});
    endtask

    initial begin
        int s0, n;
        logic [31:0] d;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst_start", {31'd0, spi_start}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_div", {24'd0, spi_clock_div}, 32'h4);
        check_status("rst_status");
        check_ctrl("rst_ctrl");

        // Single loopback word
        bus_write(A_CT, 32'h0000_0102);
        s0 = starts;
        bus_write(A_TX, 32'hA5A5_0F0F);
        settle();
        chk("one_start", starts - s0, 32'd1);
        check_status("loop_status");
        read_rx("loop_rx");

        // Overflow with the sequencer disabled, then W1C
        bus_write(A_CT, 32'h0000_0000);
        for (int i = 0; i <= DEPTH; i++) bus_write(A_TX, $urandom);
        check_status("ovf_status");
        bus_write(A_ST, 32'h0100_0000);
        check_status("ovf_clear");

        // RX back-pressure: exactly DEPTH transfers, then one more per pop
        s0 = starts;
        bus_write(A_CT, 32'h0000_0100);
        settle();
        for (int i = 0; i < 3; i++) bus_write(A_TX, $urandom);
        settle();
        chk("depth_starts", starts - s0, DEPTH);
        check_status("rx_full_status");
        read_rx("bp_rx");
        settle();
        chk("one_more_start", starts - s0, DEPTH + 1);
        check_status("bp_status");

        // Drain, underflow, RX interrupt
        bus_write(A_CT, 32'h0000_0000);
        for (int i = 0; i < DEPTH; i++) read_rx("drain_rx");
        read_rx("unf_rx");
        check_status("unf_status");
        bus_write(A_CT, 32'h0000_0300);
        settle();
        check_irq("irq_rx_on");
        while (rx_q.size() > 0) begin read_rx("irq_rx"); settle(); check_irq("irq_drain"); end

        // Div change mid-transfer only affects the next word
        bus_write(A_CT, 32'h0000_0103);
        bus_write(A_TX, $urandom);
        bus_write(A_TX, $urandom);
        n = 0;
        while (!spi_busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("busy_timeout", 32'd0, 32'd1);
        bus_write(A_CT, 32'h0000_0100);
        settle();
        while (rx_q.size() > 0) read_rx("div_rx");

        // Write and read of CTRL in one cycle returns the old value
        @(negedge clk);
        avs_address = A_CT; avs_writedata = 32'h0000_0405; avs_write = 1'b1; avs_read = 1'b1;
        d = exp_ctrl();
        m_div = 8'h05; m_en = 1'b0; m_ierx = 1'b0; m_ietxe = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        chk("wr_rd_same", avs_readdata, d);
        settle();
        check_ctrl("wr_rd_new");
        check_irq("irq_txe");

        // Randomized register traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: bus_write(A_TX, $urandom);
                1: read_rx("rnd_rx");
                2: check_status("rnd_status");
                3: bus_write(A_CT, {21'd0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 3))});
                4: bus_write(A_ST, $urandom);
                default: check_ctrl("rnd_ctrl");
            endcase
            settle();
            check_irq("rnd_irq");
        end

        // Asynchronous reset during XFER
        bus_write(A_CT, 32'h0000_0103);
        bus_write(A_TX, 32'hDEAD_BEEF);
        n = 0;
        while (!spi_busy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("busy_timeout2", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_start", {31'd0, spi_start}, 32'd0);
        chk("arst_data_in", spi_data_in, 32'd0);
        chk("arst_div", {24'd0, spi_clock_div}, 32'h4);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_rdata", avs_readdata, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check_status("post_rst_status");
        check_ctrl("post_rst_ctrl");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
